// File: rtl/pwm_multi_ch_if.sv
// Register-write bus into the PWM block: one write per cycle, no response.
interface pwm_multi_ch_if #(
    parameter int CNT_W = 32
);
    logic             wr_en;
    logic [3:0]       wr_addr;
    logic [CNT_W-1:0] wr_data;

    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM: one shared period counter, shadowed period/compare registers.
// Define PWM_CENTER_ALIGN_EN to enable up/down (center-aligned) counting via CTRL bit1.

module pwm_multi_ch_lane #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] data_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             en_i,
    input  logic             pol_i,
    output logic             pwm_o
);
    logic [CNT_W-1:0] cmp_pend_q, cmp_pend_d;
    logic [CNT_W-1:0] cmp_act_q, cmp_act_d;
    logic             pwm_q, pwm_d;

    always_comb begin
        cmp_pend_d = wr_i ? data_i : cmp_pend_q;
        // Load uses the pending next-value so a write on the boundary cycle is included
        cmp_act_d  = load_i ? cmp_pend_d : cmp_act_q;
        pwm_d      = pol_i ^ (en_i & (cmp_act_q > cnt_i));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_pend_q <= '0;
            cmp_act_q  <= '0;
            pwm_q      <= 1'b0;
        end else begin
            cmp_pend_q <= cmp_pend_d;
            cmp_act_q  <= cmp_act_d;
            pwm_q      <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;
endmodule

module pwm_multi_ch #(
    parameter int               CH_NUM         = 4,
    parameter int               CNT_W          = 32,
    parameter logic [CNT_W-1:0] DEFAULT_PERIOD = 1320000
) (
    input  logic              clk,
    input  logic              rst,
    pwm_multi_ch_if.slave     bus,
    output logic [CH_NUM-1:0] pwm_out,
    output logic              period_tick,
    output logic [CNT_W-1:0]  cnt_value
);
    localparam int CW = 2 + CH_NUM;

    logic [CNT_W-1:0]  period_pend_q, period_pend_d;
    logic [CNT_W-1:0]  period_act_q, period_act_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, top;
    logic [CW-1:0]     ctrl_q, ctrl_d;
    logic [CH_NUM-1:0] pol_q, pol_d;
    logic [CH_NUM-1:0] cmp_wr;
    logic              run_q, run_d, boundary, load;

    assign run_q = ctrl_q[0];
    assign run_d = ctrl_d[0];
    assign top   = (period_act_q < CNT_W'(2)) ? CNT_W'(1) : period_act_q - CNT_W'(1);

    always_comb begin
        period_pend_d = period_pend_q;
        ctrl_d        = ctrl_q;
        pol_d         = pol_q;
        cmp_wr        = '0;
        if (bus.wr_en) begin
            if (bus.wr_addr == 4'd0) period_pend_d = bus.wr_data;
            if (bus.wr_addr == 4'd1) ctrl_d        = bus.wr_data[CW-1:0];
            if (bus.wr_addr == 4'd2) pol_d         = bus.wr_data[CH_NUM-1:0];
            for (int i = 0; i < CH_NUM; i++)
                if (bus.wr_addr == 4'(3 + i)) cmp_wr[i] = 1'b1;
        end
    end

`ifdef PWM_CENTER_ALIGN_EN
    logic dir_q, dir_d, center_q, center_d, run_prev_q, start;

    assign start = run_q & ~run_prev_q;

    always_comb begin
        cnt_d = '0;
        dir_d = 1'b0;
        if (center_q) boundary = run_q & (start | (dir_q & (cnt_q == '0)));
        else          boundary = run_q & (cnt_q == top);
        if (run_q && run_d) begin
            if (!center_q) begin
                cnt_d = (cnt_q >= top) ? '0 : cnt_q + CNT_W'(1);
            end else if (!dir_q) begin
                // top >= 1, so turning around at top never underflows
                cnt_d = (cnt_q >= top) ? cnt_q - CNT_W'(1) : cnt_q + CNT_W'(1);
                dir_d = (cnt_q >= top);
            end else begin
                cnt_d = (cnt_q == '0) ? CNT_W'(1) : cnt_q - CNT_W'(1);
                dir_d = (cnt_q != '0);
            end
        end
        load     = ~run_q | boundary;
        center_d = load ? ctrl_d[1] : center_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q      <= 1'b0;
            center_q   <= 1'b0;
            run_prev_q <= 1'b0;
        end else begin
            dir_q      <= dir_d;
            center_q   <= center_d;
            run_prev_q <= run_q;
        end
    end
`else
    logic unused_mode;
    assign unused_mode = ctrl_q[1];

    always_comb begin
        boundary = run_q & (cnt_q == top);
        cnt_d    = (!run_q || !run_d || cnt_q >= top) ? '0 : cnt_q + CNT_W'(1);
        load     = ~run_q | boundary;
    end
`endif

    assign period_act_d = load ? period_pend_d : period_act_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            period_pend_q <= DEFAULT_PERIOD;
            period_act_q  <= DEFAULT_PERIOD;
            cnt_q         <= '0;
            ctrl_q        <= '0;
            pol_q         <= '0;
        end else begin
            period_pend_q <= period_pend_d;
            period_act_q  <= period_act_d;
            cnt_q         <= cnt_d;
            ctrl_q        <= ctrl_d;
            pol_q         <= pol_d;
        end
    end

    for (genvar g = 0; g < CH_NUM; g++) begin : g_lane
        pwm_multi_ch_lane #(.CNT_W(CNT_W)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .wr_i   (cmp_wr[g]),
            .data_i (bus.wr_data),
            .load_i (load),
            .cnt_i  (cnt_q),
            .en_i   (ctrl_q[2+g] & run_q),
            .pol_i  (pol_q[g]),
            .pwm_o  (pwm_out[g])
        );
    end

    assign period_tick = boundary;
    assign cnt_value   = cnt_q;
endmodule

// File: doc/pwm_multi_ch.md
Name: pwm_multi_ch

Overview:
- Parametrised multi-channel PWM generator: one shared period counter drives CH_NUM compare channels.
- Period and compare values are double-buffered (shadowed), so writes never glitch a running period.
- Adds per-channel enable, per-channel polarity, a period-boundary tick, and optional center-aligned mode.
- Sits behind the SoC's simple register-write interface and drives servo/LED/motor pins. Default period is 50 Hz at 66 MHz.

Parameters:
- CH_NUM, 4, number of PWM channels (1..13; bounded by the 4-bit address).
- CNT_W, 32, width of the counter, period and compare registers.
- DEFAULT_PERIOD, 1320000, period value loaded at reset (clock cycles).

Ports:
- clk  in  1  system clock
- rst  in  1  reset (see Behaviour)
- wr_en  in  1  register write strobe, one write per cycle
- wr_addr  in  4  register address
- wr_data  in  CNT_W  write data
- pwm_out  out  CH_NUM  registered PWM outputs
- period_tick  out  1  one-cycle pulse at each period boundary
- cnt_value  out  CNT_W  current counter value (debug/sync)

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: counter=0; period pending and active = DEFAULT_PERIOD; all compares = 0; ctrl=0; pol=0; pwm_out=0; period_tick=0.
- Register map (unmapped addresses ignored):
  - 0: PERIOD, shadowed.
  - 1: CTRL, not shadowed, effective next cycle. bit0 = run; bit1 = center mode; bits[2+:CH_NUM] = channel enable.
  - 2: POL, bits[CH_NUM-1:0]; effective next cycle.
  - 3+i: COMPARE[i], shadowed.
- Effective period: top = max(PERIOD_active, 2) - 1. Unsigned compare throughout; no overflow is possible since the counter never exceeds top.
- Edge mode counter: when run=1, counts 0..top and wraps to 0.
- Boundary cycle: the cycle in which cnt==top.
  - period_tick=1 in that cycle.
  - Active period and compares load from pending at the end of that cycle.
  - A write in the boundary cycle is included in that load (pending next-value is used).
- While run=0:
  - Counter is held at 0 and period_tick=0.
  - Shadows load continuously, so stopped writes take effect immediately.
- Output, per channel, registered with 1-cycle latency from cnt_value:
  - raw = en[i] & run & (COMPARE_active[i] > cnt).
  - pwm_out[i] = raw ^ pol[i].
- Duty boundaries:
  - compare=0 gives constant inactive level.
  - compare >= top+1 gives constant active level.
  - No glitch at wrap.
- run 1->0 mid-period: counter=0 on the next cycle; pwm_out = pol on the cycle after that. No tick is generated.
- run 0->1: counting starts at 0 with current shadows; the first boundary occurs after top+1 cycles.
- Reset mid-operation: all state returns to reset values on the next edge; pending writes are lost.

Optional Feature:
- Macro: PWM_CENTER_ALIGN_EN.
- Defined:
  - CTRL bit1 selects up/down counting: 0,1..top,top-1..1, then repeat; the period is 2*top cycles.
  - A direction flag is added and resets to up.
  - The boundary (tick plus shadow load) is the cycle with cnt==0 while counting down, or the first cycle after run rises.
  - A mode-bit change takes effect only at a boundary.
  - The compare rule is unchanged, which gives symmetric pulses.
- Not defined: CTRL bit1 is ignored and the counter is edge-aligned only. No direction flag is present.

Test Plan:
- Reset default: after rst, write CTRL=0x5 (run, ch0 en), COMPARE0=660000 -> pwm_out[0] high exactly 660000 of every 1320000 cycles; period_tick every 1320000 cycles; other channels 0.
- Shadowing: PERIOD=10, COMPARE1=3, running; write COMPARE1=7 at cnt=5 -> current period keeps 3 high cycles, the next period has 7; write on the boundary cycle applies to the immediately following period.
- Extremes: PERIOD=10 with COMPARE=0 -> constant 0; COMPARE=10 or 0xFFFFFFFF -> constant 1; PERIOD=0 -> top=1, cnt toggles 0,1 and tick every 2 cycles.
- Polarity/enable: POL=0x2 with ch1 disabled -> pwm_out[1]=1 constantly; enable ch1 with COMPARE1=4, PERIOD=10 -> low 4 / high 6.
- Stop/reset mid-period: clear run at cnt=6 -> cnt_value=0 next cycle, pwm_out=POL one cycle later, no tick; assert rst mid-period -> all outputs 0 and PERIOD back to 1320000.
- Center mode (macro defined): PERIOD=4, COMPARE0=2, CTRL=0x7 -> cnt sequence 0,1,2,3,2,1 repeating; pwm_out[0] delayed by 1 cycle reads 1,1,0,0,0,1; tick at cnt==0 every 6 cycles.
